// File: rtl/lcd_ctrl_pkg.sv
// Shared types for the parametrised LCD image controller: command codes,
// FSM states and the (row, col) -> frame-buffer address helper.
package lcd_ctrl_pkg;

   typedef enum logic [3:0] {
      CMD_WRITE    = 4'd0,
      CMD_UP       = 4'd1,
      CMD_DOWN     = 4'd2,
      CMD_LEFT     = 4'd3,
      CMD_RIGHT    = 4'd4,
      CMD_MAX      = 4'd5,
      CMD_MIN      = 4'd6,
      CMD_AVG      = 4'd7,
      CMD_CCW      = 4'd8,
      CMD_CW       = 4'd9,
      CMD_MIRX     = 4'd10,
      CMD_MIRY     = 4'd11,
      CMD_RELOAD   = 4'd12,
      CMD_RECENTER = 4'd13,
      CMD_NOP14    = 4'd14,
      CMD_NOP15    = 4'd15
   } cmd_t;

   typedef enum logic [2:0] {
      ST_LOAD,
      ST_IDLE,
      ST_EXEC,
      ST_WRITE,
      ST_DONE
   } state_t;

   function automatic int unsigned pix_idx(input int unsigned row,
                                           input int unsigned col,
                                           input int unsigned side);
      return row * side + col;
   endfunction

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window operator: new pixel values plus a write-enable
// for the pixel-modifying commands (Max, Min, Avg, rotates, mirrors).
module lcd_win_alu import lcd_ctrl_pkg::*; #(
   parameter int DW = 8
) (
   input  cmd_t          cmd,
   input  logic [DW-1:0] p0,
   input  logic [DW-1:0] p1,
   input  logic [DW-1:0] p2,
   input  logic [DW-1:0] p3,
   output logic [DW-1:0] n0,
   output logic [DW-1:0] n1,
   output logic [DW-1:0] n2,
   output logic [DW-1:0] n3,
   output logic          we
);

   logic [DW-1:0] mx01, mx23, mx;
   logic [DW-1:0] mn01, mn23, mn;
   logic [DW+1:0] sum;
   logic [DW-1:0] avg;

   assign mx01 = (p0 > p1) ? p0 : p1;
   assign mx23 = (p2 > p3) ? p2 : p3;
   assign mx   = (mx01 > mx23) ? mx01 : mx23;
   assign mn01 = (p0 < p1) ? p0 : p1;
   assign mn23 = (p2 < p3) ? p2 : p3;
   assign mn   = (mn01 < mn23) ? mn01 : mn23;

   // Two guard bits make the four-pixel sum exact; floor divide is a shift.
   assign sum = {2'b00, p0} + {2'b00, p1} + {2'b00, p2} + {2'b00, p3};
   assign avg = sum[DW+1:2];

   always_comb begin
      n0 = p0;
      n1 = p1;
      n2 = p2;
      n3 = p3;
      we = 1'b0;
      case (cmd)
         CMD_MAX: begin
            n0 = mx; n1 = mx; n2 = mx; n3 = mx; we = 1'b1;
         end
         CMD_MIN: begin
            n0 = mn; n1 = mn; n2 = mn; n3 = mn; we = 1'b1;
         end
         CMD_AVG: begin
            n0 = avg; n1 = avg; n2 = avg; n3 = avg; we = 1'b1;
         end
         CMD_CCW: begin
            n0 = p1; n1 = p3; n3 = p2; n2 = p0; we = 1'b1;
         end
         CMD_CW: begin
            n0 = p2; n2 = p3; n3 = p1; n1 = p0; we = 1'b1;
         end
         CMD_MIRX: begin
            n0 = p2; n2 = p0; n1 = p3; n3 = p1; we = 1'b1;
         end
         CMD_MIRY: begin
            n0 = p1; n1 = p0; n2 = p3; n3 = p2; we = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lcd_ctrl_gen.sv
// LCD image controller: loads an NxN image from ROM, edits a 2x2 window on command,
// dumps the frame to RAM on Write; busy high means cmd is ignored (nothing queued).
module lcd_ctrl_gen import lcd_ctrl_pkg::*; #(
   parameter int N  = 8,
   parameter int DW = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [3:0]             cmd,
   input  logic                   cmd_valid,
   output logic                   IROM_rd,
   output logic [2*$clog2(N)-1:0] IROM_A,
   input  logic [DW-1:0]          IROM_Q,
   output logic                   IRAM_valid,
   output logic [2*$clog2(N)-1:0] IRAM_A,
   output logic [DW-1:0]          IRAM_D,
   output logic                   busy,
   output logic                   done
);

   localparam int CW = $clog2(N);
   localparam int AW = 2 * CW;
   localparam int NN = N * N;
   localparam logic [CW-1:0] HALF = CW'(N / 2);
   localparam logic [CW-1:0] PMAX = CW'(N - 1);
   localparam logic [CW-1:0] PONE = CW'(1);
   localparam logic [AW-1:0] LAST = AW'(NN - 1);
   localparam logic [AW-1:0] AONE = AW'(1);

   state_t        state, state_nxt;
   cmd_t          cmd_in, cmd_q, cmd_nxt;
   logic [CW-1:0] x, y, x_nxt, y_nxt;
   logic          rom_rd_nxt, ram_vld_nxt, busy_nxt, done_nxt;
   logic [AW-1:0] rom_a_nxt, ram_a_nxt;
   logic          cap, win_we;

   logic [DW-1:0] fb [NN];
   logic [AW-1:0] a0, a1, a2, a3;
   logic [DW-1:0] w0, w1, w2, w3;
   logic          alu_we;

   assign cmd_in = cmd_t'(cmd);

   assign a0 = AW'(pix_idx(32'(y) - 32'd1, 32'(x) - 32'd1, N));
   assign a1 = AW'(pix_idx(32'(y) - 32'd1, 32'(x),         N));
   assign a2 = AW'(pix_idx(32'(y),         32'(x) - 32'd1, N));
   assign a3 = AW'(pix_idx(32'(y),         32'(x),         N));

   lcd_win_alu #(.DW(DW)) u_alu (
      .cmd (cmd_q),
      .p0  (fb[a0]),
      .p1  (fb[a1]),
      .p2  (fb[a2]),
      .p3  (fb[a3]),
      .n0  (w0),
      .n1  (w1),
      .n2  (w2),
      .n3  (w3),
      .we  (alu_we)
   );

   // Data is forced to zero outside the dump so reset leaves every output quiet.
   assign IRAM_D = IRAM_valid ? fb[IRAM_A] : '0;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= ST_LOAD;
         IROM_rd    <= 1'b0;
         IROM_A     <= '0;
         IRAM_valid <= 1'b0;
         IRAM_A     <= '0;
         busy       <= 1'b1;
         done       <= 1'b0;
         cmd_q      <= CMD_WRITE;
         x          <= HALF;
         y          <= HALF;
      end else begin
         state      <= state_nxt;
         IROM_rd    <= rom_rd_nxt;
         IROM_A     <= rom_a_nxt;
         IRAM_valid <= ram_vld_nxt;
         IRAM_A     <= ram_a_nxt;
         busy       <= busy_nxt;
         done       <= done_nxt;
         cmd_q      <= cmd_nxt;
         x          <= x_nxt;
         y          <= y_nxt;
      end
   end

   // Window update reads old pixels and writes all four on the same edge.
   always_ff @(posedge clk) begin
      if (cap) begin
         fb[IROM_A] <= IROM_Q;
      end
      if (win_we) begin
         fb[a0] <= w0;
         fb[a1] <= w1;
         fb[a2] <= w2;
         fb[a3] <= w3;
      end
   end

   always_comb begin
      state_nxt   = state;
      rom_rd_nxt  = IROM_rd;
      rom_a_nxt   = IROM_A;
      ram_vld_nxt = 1'b0;
      ram_a_nxt   = IRAM_A;
      cmd_nxt     = cmd_q;
      x_nxt       = x;
      y_nxt       = y;
      cap         = 1'b0;
      win_we      = 1'b0;
      case (state)
         ST_LOAD: begin
            // First LOAD cycle after reset or Reload only issues address 0.
            if (!IROM_rd) begin
               rom_rd_nxt = 1'b1;
               rom_a_nxt  = '0;
            end else begin
               cap = 1'b1;
               if (IROM_A == LAST) begin
                  rom_rd_nxt = 1'b0;
                  state_nxt  = ST_IDLE;
               end else begin
                  rom_a_nxt = IROM_A + AONE;
               end
            end
         end
         ST_IDLE: begin
            if (cmd_valid && !busy) begin
               cmd_nxt = cmd_in;
               if (cmd_in == CMD_WRITE) begin
                  state_nxt   = ST_WRITE;
                  ram_vld_nxt = 1'b1;
                  ram_a_nxt   = '0;
               end else if (cmd_in == CMD_RELOAD) begin
                  state_nxt  = ST_LOAD;
                  rom_rd_nxt = 1'b0;
                  x_nxt      = HALF;
                  y_nxt      = HALF;
               end else begin
                  state_nxt = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            state_nxt = ST_IDLE;
            win_we    = alu_we;
            case (cmd_q)
               CMD_UP:       if (y > PONE) y_nxt = y - PONE;
               CMD_DOWN:     if (y < PMAX) y_nxt = y + PONE;
               CMD_LEFT:     if (x > PONE) x_nxt = x - PONE;
               CMD_RIGHT:    if (x < PMAX) x_nxt = x + PONE;
               CMD_RECENTER: begin
                  x_nxt = HALF;
                  y_nxt = HALF;
               end
               default: ;
            endcase
         end
         ST_WRITE: begin
            if (IRAM_A == LAST) begin
               state_nxt = ST_DONE;
            end else begin
               ram_vld_nxt = 1'b1;
               ram_a_nxt   = IRAM_A + AONE;
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
         end
         default: begin
            state_nxt = ST_LOAD;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
      done_nxt = (state_nxt == ST_DONE);
   end

endmodule

// File: tb/tb_lcd_ctrl_gen.sv
// Directed bench for lcd_ctrl_gen (N=8, DW=8) with behavioural ROM/RAM models
// that sample on the falling clock edge.
module tb_lcd_ctrl_gen;

   localparam int N  = 8;
   localparam int DW = 8;
   localparam int AW = 6;
   localparam int NN = 64;
   localparam int W0 = 27, W1 = 28, W2 = 35, W3 = 36;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [3:0]    cmd = 4'd0;
   logic          cmd_valid = 1'b0;
   logic          IROM_rd;
   logic [AW-1:0] IROM_A;
   logic [DW-1:0] IROM_Q;
   logic          IRAM_valid;
   logic [AW-1:0] IRAM_A;
   logic [DW-1:0] IRAM_D;
   logic          busy;
   logic          done;

   logic [DW-1:0] rom [NN];
   logic [DW-1:0] ram [NN];
   int n_cmp = 0;
   int n_err = 0;
   int wr_cnt = 0;
   int done_cnt = 0;
   int overlap = 0;
   int d0, n;
   logic [3:0] hseq [3];

   always #5 clk = ~clk;

   lcd_ctrl_gen #(.N(N), .DW(DW)) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd        (cmd),
      .cmd_valid  (cmd_valid),
      .IROM_rd    (IROM_rd),
      .IROM_A     (IROM_A),
      .IROM_Q     (IROM_Q),
      .IRAM_valid (IRAM_valid),
      .IRAM_A     (IRAM_A),
      .IRAM_D     (IRAM_D),
      .busy       (busy),
      .done       (done)
   );

   always @(negedge clk) begin
      if (IROM_rd) IROM_Q <= rom[IROM_A];
      if (IRAM_valid) begin
         ram[IRAM_A] <= IRAM_D;
         wr_cnt <= wr_cnt + 1;
      end
      if (done) done_cnt <= done_cnt + 1;
      if (done && IRAM_valid) overlap <= overlap + 1;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", tag, got, want);
      end
   endtask

   task automatic wait_idle;
      int k = 0;
      while (busy && k < 300) begin
         tick;
         k++;
      end
      if (busy) check_eq("idle_timeout", {31'd0, busy}, 0);
   endtask

   task automatic send(input logic [3:0] c);
      wait_idle;
      cmd = c;
      cmd_valid = 1'b1;
      tick;
      cmd_valid = 1'b0;
   endtask

   task automatic run(input logic [3:0] c);
      send(c);
      wait_idle;
   endtask

   task automatic do_write(input string tag);
      int c = 0;
      int w_start = wr_cnt;
      int d_start = done_cnt;
      send(4'd0);
      while (!done && c < 200) begin
         tick;
         c++;
      end
      check_eq({tag, "_done_latency"}, c, 64);
      check_eq({tag, "_busy_in_done"}, {31'd0, busy}, 1);
      tick;
      check_eq({tag, "_busy_done_after"}, {30'd0, busy, done}, 0);
      check_eq({tag, "_nwrites"}, wr_cnt - w_start, 64);
      check_eq({tag, "_ndone"}, done_cnt - d_start, 1);
   endtask

   task automatic check4(input string tag, input int a0, input int a1, input int a2, input int a3,
                         input int v0, input int v1, input int v2, input int v3);
      check_eq({tag, "_p0"}, {24'd0, ram[a0]}, v0);
      check_eq({tag, "_p1"}, {24'd0, ram[a1]}, v1);
      check_eq({tag, "_p2"}, {24'd0, ram[a2]}, v2);
      check_eq({tag, "_p3"}, {24'd0, ram[a3]}, v3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < NN; k++) rom[k] = 8'(k);
      hseq[0] = 4'd4;
      hseq[1] = 4'd4;
      hseq[2] = 4'd0;

      // reset values
      #1 reset = 1'b0;
      #2;
      check_eq("rst_busy", {31'd0, busy}, 1);
      check_eq("rst_outs", {IROM_rd, IRAM_valid, done, IROM_A, IRAM_A, IRAM_D}, 0);

      // LOAD timing: address k in cycle k, busy low after 65 edges
      #20;
      @(negedge clk) reset = 1'b1;
      tick;
      check_eq("load_c0", {IROM_rd, 1'b0, IROM_A}, {1'b1, 1'b0, 6'd0});
      tick;
      check_eq("load_c1", {IROM_rd, 1'b0, IROM_A}, {1'b1, 1'b0, 6'd1});
      repeat (62) tick;
      check_eq("load_c63", {IROM_rd, busy, IROM_A}, {1'b1, 1'b1, 6'd63});
      tick;
      check_eq("load_end", {30'd0, busy, IROM_rd}, 0);

      do_write("dump0");
      for (int k = 0; k < NN; k++) check_eq("dump0_word", {24'd0, ram[k]}, k);

      // walk to (1,1) with saturation, then Max on {0,1,8,9}
      repeat (5) run(4'd3);
      repeat (5) run(4'd1);
      run(4'd5);
      do_write("dump1");
      check4("max", 0, 1, 8, 9, 9, 9, 9, 9);
      check_eq("max_nb2", {24'd0, ram[2]}, 2);
      check_eq("max_nb10", {24'd0, ram[10]}, 10);

      // cmd_valid held high through Right, Right, Write
      d0 = done_cnt;
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd = hseq[i];
         n = 0;
         while (busy && n < 300) begin
            tick;
            n++;
         end
         tick;
         check_eq("hold_accept", {31'd0, busy}, 1);
      end
      cmd_valid = 1'b0;
      n = 0;
      while (!done && n < 200) begin
         tick;
         n++;
      end
      check_eq("hold_done_seen", {31'd0, done}, 1);
      repeat (4) tick;
      check_eq("hold_idle", {31'd0, busy}, 0);
      check_eq("hold_ndone", done_cnt - d0, 1);

      // point must now be (3,1): MirrorY on {2,3,10,11}
      run(4'd11);
      do_write("dump3");
      check4("miry", 2, 3, 10, 11, 3, 2, 11, 10);

      // Write, Min, Write
      d0 = done_cnt;
      do_write("dump4a");
      run(4'd6);
      do_write("dump4b");
      check_eq("two_dones", done_cnt - d0, 2);
      check4("min", 2, 3, 10, 11, 2, 2, 2, 2);

      // Reload restores image and point (4,4)
      run(4'd12);
      run(4'd11);
      do_write("dump5");
      check4("reload_miry", W0, W1, W2, W3, 28, 27, 36, 35);
      check_eq("reload_a0", {24'd0, ram[0]}, 0);
      check_eq("reload_a2", {24'd0, ram[2]}, 2);

      // saturate at (7,7), Min, then Recenter + no-ops + MirrorY undoes the swap
      repeat (5) run(4'd4);
      repeat (5) run(4'd2);
      run(4'd6);
      run(4'd13);
      run(4'd14);
      run(4'd15);
      run(4'd11);
      do_write("dump6");
      check4("sat_min", 54, 55, 62, 63, 54, 54, 54, 54);
      check4("recenter", W0, W1, W2, W3, 27, 28, 35, 36);

      // Avg at full scale
      rom[W0] = 8'd255; rom[W1] = 8'd255; rom[W2] = 8'd255; rom[W3] = 8'd254;
      run(4'd12);
      run(4'd7);
      do_write("dump7");
      check4("avg", W0, W1, W2, W3, 254, 254, 254, 254);
      check_eq("avg_reload54", {24'd0, ram[54]}, 54);

      // rotations and MirrorX on {1,2,3,4}
      rom[W0] = 8'd1; rom[W1] = 8'd2; rom[W2] = 8'd3; rom[W3] = 8'd4;
      run(4'd12);
      run(4'd9);
      do_write("dump8");
      check4("cw", W0, W1, W2, W3, 3, 1, 4, 2);
      run(4'd8);
      do_write("dump9");
      check4("ccw", W0, W1, W2, W3, 1, 2, 3, 4);
      run(4'd10);
      do_write("dump10");
      check4("mirx", W0, W1, W2, W3, 3, 4, 1, 2);

      // reset during cycle 20 of a WRITE
      send(4'd0);
      repeat (20) tick;
      check_eq("midwr_addr", {IRAM_valid, 1'b0, IRAM_A}, {1'b1, 1'b0, 6'd20});
      reset = 1'b0;
      #1;
      check_eq("midwr_busy", {31'd0, busy}, 1);
      check_eq("midwr_outs", {IROM_rd, IRAM_valid, done, IROM_A, IRAM_A, IRAM_D}, 0);
      @(negedge clk) reset = 1'b1;
      tick;
      check_eq("reload_c0", {IROM_rd, 1'b0, IROM_A}, {1'b1, 1'b0, 6'd0});
      tick;
      check_eq("reload_c1", {IROM_rd, 1'b0, IROM_A}, {1'b1, 1'b0, 6'd1});
      wait_idle;

      check_eq("done_with_valid", overlap, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/lcd_ctrl_gen.md
# lcd_ctrl_gen

Parametrised successor to the LCD image controller. After reset, it loads an N×N image of DW-bit pixels from the image ROM into an internal frame buffer. It then applies accepted commands to a 2×2 operation window. On a Write command it dumps the whole buffer to the image RAM. Unlike the fixed 8×8 controller, it returns to accepting commands after `done`, so several frames can be written out in one run. It also adds Reload and Recenter commands.

## Interface
- `N`, default 8: image side; power of 2, range 4..16.
- `DW`, default 8: pixel width.
- `AW`, default 2·log2(N): derived, not overridable; pixel address width.
- `clk` input, 1 bit: rising-edge clock.
- `reset` input, 1 bit: reset, asynchronous, active-low.
- `cmd` input, 4 bits: command code.
- `cmd_valid` input, 1 bit: command qualifier.
- `IROM_rd` output, 1 bit: ROM read enable. The ROM samples the address on the falling edge of `clk`.
- `IROM_A` output, AW bits: ROM address.
- `IROM_Q` input, DW bits: ROM data, valid on the rising edge after the request.
- `IRAM_valid` output, 1 bit: RAM write enable. The RAM writes on the falling edge of `clk`.
- `IRAM_A` output, AW bits: RAM address.
- `IRAM_D` output, DW bits: RAM data.
- `busy` output, 1 bit: high means `cmd` is ignored.
- `done` output, 1 bit: one-cycle pulse after a complete dump.

## Operation
- Frame buffer: N·N × DW registers. Address = row·N + col.
- Operation point: (x, y), each in [1, N−1]. Value after reset, Reload or Recenter: (N/2, N/2).
- Window pixels:
  - P0 = (x−1, y−1), P1 = (x, y−1)
  - P2 = (x−1, y), P3 = (x, y)
- Commands:
  - 0 Write: dump the frame buffer to RAM.
  - 1 Up: y−1. 2 Down: y+1. 3 Left: x−1. 4 Right: x+1.
  - Shifts saturate at 1 and N−1. A shift at a boundary is a no-op but is still accepted.
  - 5 Max, 6 Min: all four pixels take the extreme value.
  - 7 Avg: all four pixels take floor((P0+P1+P2+P3)/4). The sum is computed at DW+2 bits; no overflow is possible.
  - 8 CCW rotate: P0←P1, P1←P3, P3←P2, P2←P0.
  - 9 CW rotate: P0←P2, P2←P3, P3←P1, P1←P0.
  - 10 MirrorX: swap P0↔P2 and P1↔P3.
  - 11 MirrorY: swap P0↔P1 and P2↔P3.
  - 12 Reload: re-run the ROM load and recenter the point.
  - 13 Recenter: move the point to (N/2, N/2).
  - 14, 15: no-op, accepted.
- All window updates read the old values and write the new values on the same edge.
- States and transitions:
  - LOAD → IDLE after the last ROM word is captured.
  - IDLE → EXEC on acceptance of codes 1–11, 13, 14, 15.
  - IDLE → WRITE on code 0.
  - IDLE → LOAD on code 12.
  - EXEC → IDLE after one cycle.
  - WRITE → DONE after address N·N−1 is written.
  - DONE → IDLE after one cycle.

## Timing
- Reset values (with `reset` low):
  - `busy` = 1; all other outputs = 0.
  - Point = (N/2, N/2).
  - Buffer contents: don't-care.
  - State = LOAD.
- Reset asserted mid-LOAD or mid-WRITE aborts the operation immediately. After release, the block restarts at LOAD, address 0. RAM contents already written are left as they are.
- Command acceptance:
  - A command is accepted at a rising edge where `cmd_valid` = 1 and `busy` = 0.
  - `busy` rises on that same edge.
  - `cmd_valid` while `busy` = 1 is ignored; nothing is queued.
- LOAD:
  - The ROM address for word k is presented in cycle k with `IROM_rd` = 1.
  - Word k is captured at the next rising edge.
  - Total duration: N·N+1 cycles. `IROM_rd` drops in the final capture cycle.
  - `busy` falls on the edge that enters IDLE.
- EXEC: `busy` is high for exactly 1 cycle. The result is visible in the buffer on the edge where `busy` falls.
- WRITE:
  - Address k is driven in cycle k with `IRAM_valid` = 1, giving N·N consecutive writes with no gaps.
  - `IRAM_valid` = 0 in the DONE cycle.
  - `done` = 1 for exactly that DONE cycle; `busy` stays 1 through it.
  - `busy` falls on the next edge.
- `done` never coincides with `IRAM_valid`.

## Structure
- Package `lcd_ctrl_pkg` holds:
  - the command enum (codes 0–15);
  - the state enum (LOAD, IDLE, EXEC, WRITE, DONE);
  - the pixel-index helper function (row, col → address).
- Sub-module `lcd_win_alu`:
  - combinational;
  - inputs: four DW-bit pixels and the command;
  - outputs: four new pixel values plus a write-enable.
- The top level owns the FSM, counters, point registers and frame buffer.

## Test plan
- Reset release with the ROM holding value k at address k (N=8): `busy` is low after 65 cycles. An immediate Write writes RAM[k] = k for k = 0..63, then `done` pulses once.
- Left ×5, then Up ×5 from (4,4) gives point (1,1). Then Max on window values {0, 1, 8, 9} sets addresses 0, 1, 8, 9 to 9. Then Write.
- Avg on {255, 255, 255, 254}: all four pixels become 254. Next, CW on {1, 2, 3, 4} (P0..P3) gives {3, 1, 4, 2}. Next, CCW restores {1, 2, 3, 4}. MirrorX gives {3, 4, 1, 2}.
- Hold `cmd_valid` = 1 throughout with commands Right, Right, Write: each command is accepted only while `busy` is low. No command is lost or duplicated.
- Write, then Min, then a second Write: two `done` pulses. The second dump reflects the Min result. Then Reload restores the ROM image and point (4,4).
- Assert `reset` in cycle 20 of a WRITE: outputs return to their reset values within the same cycle. After release, LOAD restarts at address 0.
